dev_uart_responder: RTL
=======================

Name: dev_uart_responder

Overview:
- Memory-mapped UART peripheral on the external device port of the memory controller, i.e. address window addr[19:18]=2.
- It is the responder end of that port: it accepts devClkEn/devWriteEn/devAddr/devData and returns devQ with the same one-cycle registered read latency as the on-chip ROM/RAM.
- Contains a TX FIFO feeding an 8N1 transmitter, plus an 8N1 receiver with a one-byte holding register.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2).
- DIV_RESET, 16'd433, reset value of the baud divisor. Bit period = DIV+1 clk cycles.

Ports:
- clk  in  1  clock, same net as the controller's devClk.
- nrst  in  1  reset, asynchronous, active-low (devNrst).
- clk_en  in  1  access strobe (devClkEn).
- write_en  in  1  1=write, 0=read; qualified by clk_en (devWriteEn).
- addr  in  18  word address (devAddr).
- data  in  32  write data (devData).
- q  out  32  registered read data (devQ).
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous.
- irq  out  1  level interrupt.

Behaviour:
- Register map. Decoded when addr[17:2]==0; any other address reads 0 and ignores writes.
  - 0 TXDATA: W pushes data[7:0]; R returns 0.
  - 1 RXDATA: R returns {23'b0, rx_valid, rx_byte} and clears rx_valid; W ignored.
  - 2 STATUS: R returns [0] tx_full, [1] tx_empty, [2] tx_busy, [3] rx_valid, [4] rx_overrun, [5] rx_frame_err, [6] tx_overflow. W: a 1 written to bits 4/5/6 clears that bit (W1C).
  - 3 CTRL: R/W [15:0] div, [16] rx_ie, [17] tx_ie.
- Bus timing:
  - Read: at the posedge with clk_en=1 and write_en=0, q <= register value sampled before that edge's updates. q holds between reads.
  - Write: takes effect at the posedge with clk_en=1 and write_en=1; q unchanged.
- irq = (rx_valid & rx_ie) | (tx_empty & ~tx_busy & tx_ie), combinational from registers.
- TX FIFO:
  - Push on a TXDATA write.
  - When full, the push is dropped and tx_overflow is set, unless a pop occurs on the same edge; then the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- TX FSM (states T_IDLE, T_START, T_DATA, T_STOP; tx_busy = state != T_IDLE):
  - T_IDLE with FIFO non-empty: pop, load shifter, tx<=0, go to T_START.
  - Each state lasts div+1 cycles (baud counter reloads from div at each bit boundary).
  - T_DATA sends 8 bits LSB first. T_STOP drives tx=1, then returns to T_IDLE.
  - Back-to-back frames have no idle gap.
  - A TXDATA write at edge N into an empty FIFO makes tx fall at edge N+1.
  - A div write mid-frame applies from the next bit boundary.
- RX:
  - rx passes through a 2-FF synchronizer (reset value 1).
  - R_IDLE: on a synchronized falling edge, go to R_START.
  - R_START: wait (div+1)/2 cycles and re-check. If rx=1 it was a glitch; return to R_IDLE without setting flags. Otherwise go to R_DATA.
  - R_DATA: sample 8 bits at intervals of div+1, LSB first.
  - R_STOP: sample the stop bit after div+1 cycles, then return to R_IDLE.
  - Stop bit = 1: rx_byte <= new byte and rx_valid <= 1. If rx_valid was already set and is not being cleared this edge, also set rx_overrun (the new byte overwrites).
  - Stop bit = 0: set rx_frame_err; byte discarded; rx_valid unchanged.
- Simultaneous events:
  - RXDATA read and byte completion on the same edge: q gets the old byte; rx_valid ends at 1 with the new byte; no overrun.
  - W1C write and a set event on the same edge: set wins.
- Reset (any time, including mid-frame), asynchronous:
  - q=0, tx=1, FIFO empty, both FSMs idle, all flags 0, div=DIV_RESET, rx_ie=tx_ie=0, synchronizer=1.
  - An in-flight frame is abandoned, with no partial frame after release.

Decomposition:
- Package dev_uart_pkg:
  - register word addresses (0–3);
  - STATUS bit indices;
  - CTRL field positions;
  - TX/RX state encodings;
  - DIV_W=16.
- Sub-module dev_uart_fifo: synchronous FIFO, DEPTH and WIDTH=8 parameters.
  - Ports: push, pop, din, dout, full, empty.
  - Same-edge push/pop when full is allowed.

Test Plan:
- Reset release → q=0, tx=1. Read STATUS → q=32'h2 on the edge after the read strobe. Read addr 4 → q=0.
- Write CTRL=3, TXDATA=8'hA5 at edge N → tx=0 from edge N+1 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1. STATUS reads 32'h4 mid-frame and 32'h2 after.
- DIV=3: push 6 bytes one access every 3 cycles → bytes 1–5 sent back-to-back, 6th dropped, STATUS[6]=1. Write STATUS=32'h40 → bit 6 cleared.
- Drive rx frame 8'h3C at 4-cycle bits → STATUS[3]=1. RXDATA read → q=32'h13C. Next RXDATA read → q=32'h03C.
- Two frames 8'h11 then 8'h22 without a read → RXDATA=32'h122, STATUS[4]=1. Frame with stop=0 → STATUS[5]=1. A 1-cycle rx low pulse → no flag change.
- CTRL rx_ie=1 + received byte → irq=1; RXDATA read clears it. nrst low mid-TX-frame → tx=1 immediately, STATUS=32'h2 after release.

Source files
------------

// File: rtl/dev_uart_pkg.sv
// Shared constants for the device-port UART: register map, field positions, FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dev_uart_pkg;

  localparam int DIV_W = 16;

  // Register word addresses (addr[1:0] once addr[17:2] decodes to zero)
  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_RXDATA = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  // STATUS bit indices
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_TX_BUSY   = 2;
  localparam int ST_RX_VALID  = 3;
  localparam int ST_RX_OVR    = 4;
  localparam int ST_RX_FERR   = 5;
  localparam int ST_TX_OVF    = 6;

  // CTRL field positions
  localparam int CTRL_DIV_LSB = 0;
  localparam int CTRL_DIV_MSB = 15;
  localparam int CTRL_RX_IE   = 16;
  localparam int CTRL_TX_IE   = 17;

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} txState_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rxState_t;

  // Countdown preload that re-checks the start bit (div+1)/2 cycles after the
  // synchronised falling edge; a zero half-period degenerates to an immediate check.
  function automatic logic [DIV_W-1:0] halfWait(input logic [DIV_W-1:0] div);
    logic [DIV_W:0]   bitLen;
    logic [DIV_W-1:0] half;
    bitLen = {1'b0, div} + (DIV_W+1)'(1);
    half   = bitLen[DIV_W:1];
    halfWait = (half == '0) ? '0 : half - DIV_W'(1);
  endfunction

endpackage

// File: rtl/dev_uart_responder_if.sv
// Device-port bus bundle between the memory controller (master) and a responder (slave).
// Latency: read data returns one cycle after the strobe edge, registered in the responder.
// Backpressure: none; every strobed access completes in its cycle.
// Signals: clk_en access strobe, write_en 1=write, addr word address, data write data, q read data.
interface dev_uart_responder_if;
  logic        clk_en;
  logic        write_en;
  logic [17:0] addr;
  logic [31:0] data;
  logic [31:0] q;

  modport master (output clk_en, write_en, addr, data, input q);
  modport slave  (input clk_en, write_en, addr, data, output q);
endinterface

// File: rtl/dev_uart_fifo.sv
// Synchronous FIFO with first-word fall-through read port (dout valid whenever !empty).
// Latency: a push is visible on dout the cycle after it is written into an empty FIFO.
// Backpressure: pushes while full are dropped unless a pop happens on the same edge.
// Ports: push/din write side, pop/dout read side, full/empty status.
module dev_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop & ~empty;
  // The slot freed by a same-edge pop makes room for the push.
  assign doPush = push & (~full | doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dev_uart_responder.sv
// Memory-mapped 8N1 UART on the controller's device port: TX FIFO + transmitter, receiver + holding register.
// Latency: reads return on q at the strobe edge (one-cycle registered, like on-chip ROM/RAM); writes act at the strobe edge.
// Backpressure: none on the bus; TXDATA writes into a full FIFO are dropped and flagged in tx_overflow.
// Ports: clk, nrst (async active-low), bus (device-port slave), tx serial out (idle high), rx serial in (async), irq level.
module dev_uart_responder
  import dev_uart_pkg::*;
#(
  parameter int               FIFO_DEPTH = 4,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd433
) (
  input  logic                 clk,
  input  logic                 nrst,
  dev_uart_responder_if.slave  bus,
  output logic                 tx,
  input  logic                 rx,
  output logic                 irq
);

  // ---------------- bus decode ----------------
  logic hit, rdStb, wrStb;
  logic wrTx, rdRx, wrStat, wrCtrl;
  logic unusedData;

  assign hit    = (bus.addr[17:2] == '0);
  assign rdStb  = bus.clk_en & ~bus.write_en;
  assign wrStb  = bus.clk_en &  bus.write_en;
  assign wrTx   = wrStb & hit & (bus.addr[1:0] == A_TXDATA);
  assign rdRx   = rdStb & hit & (bus.addr[1:0] == A_RXDATA);
  assign wrStat = wrStb & hit & (bus.addr[1:0] == A_STATUS);
  assign wrCtrl = wrStb & hit & (bus.addr[1:0] == A_CTRL);
  assign unusedData = ^bus.data[31:18];

  // ---------------- registers ----------------
  logic [DIV_W-1:0] div;
  logic             rxIe, txIe;
  logic             rxValid, rxOverrun, rxFrameErr, txOverflow;
  logic [7:0]       rxByte;

  // ---------------- TX path ----------------
  logic             fifoFull, fifoEmpty, txPop;
  logic [7:0]       fifoDout;
  txState_t         txState;
  logic [DIV_W-1:0] txCnt;
  logic [2:0]       txBit;
  logic [7:0]       txShift;
  logic             txBoundary, txBusy, txEmpty;

  assign txBoundary = (txCnt == '0);
  assign txBusy     = (txState != T_IDLE);
  // Reported empty only once the whole transmit path has drained.
  assign txEmpty    = fifoEmpty & ~txBusy;
  // Pop at idle, or at the end of a stop bit so frames run back-to-back.
  assign txPop      = ~fifoEmpty &
                      ((txState == T_IDLE) | ((txState == T_STOP) & txBoundary));

  dev_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) uFifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (wrTx),
    .pop   (txPop),
    .din   (bus.data[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      txState <= T_IDLE;
      txCnt   <= '0;
      txBit   <= '0;
      txShift <= '0;
      tx      <= 1'b1;
    end else begin
      case (txState)
        T_IDLE: begin
          if (txPop) begin
            txShift <= fifoDout;
            txCnt   <= div;
            tx      <= 1'b0;
            txState <= T_START;
          end
        end
        default: begin
          if (!txBoundary) begin
            txCnt <= txCnt - DIV_W'(1);
          end else begin
            // div is re-read at every bit boundary, so CTRL writes land on the next bit.
            txCnt <= div;
            case (txState)
              T_START: begin
                tx      <= txShift[0];
                txShift <= {1'b0, txShift[7:1]};
                txBit   <= '0;
                txState <= T_DATA;
              end
              T_DATA: begin
                if (txBit == 3'd7) begin
                  tx      <= 1'b1;
                  txState <= T_STOP;
                end else begin
                  tx      <= txShift[0];
                  txShift <= {1'b0, txShift[7:1]};
                  txBit   <= txBit + 3'd1;
                end
              end
              default: begin
                if (txPop) begin
                  txShift <= fifoDout;
                  tx      <= 1'b0;
                  txState <= T_START;
                end else begin
                  txState <= T_IDLE;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic             rxMeta, rxSync, rxPrev;
  rxState_t         rxState;
  logic [DIV_W-1:0] rxCnt;
  logic [2:0]       rxBit;
  logic [7:0]       rxShift;
  logic             rxStopEv, rxGood, rxBad;

  assign rxStopEv = (rxState == R_STOP) & (rxCnt == '0);
  assign rxGood   = rxStopEv &  rxSync;
  assign rxBad    = rxStopEv & ~rxSync;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rxMeta  <= 1'b1;
      rxSync  <= 1'b1;
      rxPrev  <= 1'b1;
      rxState <= R_IDLE;
      rxCnt   <= '0;
      rxBit   <= '0;
      rxShift <= '0;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
      case (rxState)
        R_IDLE: begin
          if (rxPrev & ~rxSync) begin
            rxCnt   <= halfWait(div);
            rxState <= R_START;
          end
        end
        R_START: begin
          if (rxCnt != '0) begin
            rxCnt <= rxCnt - DIV_W'(1);
          end else if (rxSync) begin
            rxState <= R_IDLE;   // line back high: glitch, not a start bit
          end else begin
            rxCnt   <= div;
            rxBit   <= '0;
            rxState <= R_DATA;
          end
        end
        R_DATA: begin
          if (rxCnt != '0) begin
            rxCnt <= rxCnt - DIV_W'(1);
          end else begin
            rxShift <= {rxSync, rxShift[7:1]};
            rxCnt   <= div;
            if (rxBit == 3'd7) rxState <= R_STOP;
            else               rxBit   <= rxBit + 3'd1;
          end
        end
        default: begin
          if (rxCnt != '0) rxCnt   <= rxCnt - DIV_W'(1);
          else             rxState <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------- read mux ----------------
  logic [31:0] rdData;

  always_comb begin
    rdData = '0;
    if (hit) begin
      case (bus.addr[1:0])
        A_RXDATA: rdData = {23'b0, rxValid, rxByte};
        A_STATUS: begin
          rdData[ST_TX_FULL]  = fifoFull;
          rdData[ST_TX_EMPTY] = txEmpty;
          rdData[ST_TX_BUSY]  = txBusy;
          rdData[ST_RX_VALID] = rxValid;
          rdData[ST_RX_OVR]   = rxOverrun;
          rdData[ST_RX_FERR]  = rxFrameErr;
          rdData[ST_TX_OVF]   = txOverflow;
        end
        A_CTRL: begin
          rdData[CTRL_DIV_MSB:CTRL_DIV_LSB] = div;
          rdData[CTRL_RX_IE]                = rxIe;
          rdData[CTRL_TX_IE]                = txIe;
        end
        default: rdData = '0;
      endcase
    end
  end

  // ---------------- register updates ----------------
  // Set events take priority over read-clear and W1C on the same edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.q      <= '0;
      div        <= DIV_RESET;
      rxIe       <= 1'b0;
      txIe       <= 1'b0;
      rxValid    <= 1'b0;
      rxByte     <= '0;
      rxOverrun  <= 1'b0;
      rxFrameErr <= 1'b0;
      txOverflow <= 1'b0;
    end else begin
      if (rdStb) bus.q <= rdData;

      if (wrCtrl) begin
        div  <= bus.data[CTRL_DIV_MSB:CTRL_DIV_LSB];
        rxIe <= bus.data[CTRL_RX_IE];
        txIe <= bus.data[CTRL_TX_IE];
      end

      if (rxGood) begin
        rxByte  <= rxShift;
        rxValid <= 1'b1;
      end else if (rdRx) begin
        rxValid <= 1'b0;
      end

      if (rxGood & rxValid & ~rdRx)          rxOverrun <= 1'b1;
      else if (wrStat & bus.data[ST_RX_OVR]) rxOverrun <= 1'b0;

      if (rxBad)                              rxFrameErr <= 1'b1;
      else if (wrStat & bus.data[ST_RX_FERR]) rxFrameErr <= 1'b0;

      if (wrTx & fifoFull & ~txPop)          txOverflow <= 1'b1;
      else if (wrStat & bus.data[ST_TX_OVF]) txOverflow <= 1'b0;
    end
  end

  assign irq = (rxValid & rxIe) | (txEmpty & ~txBusy & txIe);

endmodule
